// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: round-robin 2:1 AXI4-Lite arbiter with independent write and read paths.
module axil_arbiter_2to1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    localparam int STRB_WIDTH = DATA_WIDTH / 8 + 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [RESP_WIDTH-1:0] s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [RESP_WIDTH-1:0] s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [RESP_WIDTH-1:0] s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [RESP_WIDTH-1:0] s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [RESP_WIDTH-1:0] m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [RESP_WIDTH-1:0] m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_BACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_BACK} r_state_t;
    w_state_t w_state;
    r_state_t r_state;
    logic w_gnt, last_wgrant, r_gnt, last_rgrant;
    logic [RESP_WIDTH-1:0] bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic w_req0, w_req1, w_win, w_acc, w_back0, w_back1, w_done;
    logic r_req0, r_req1, r_win, r_acc, r_back0, r_back1, r_done;
    // Readies are gated by reset so nothing handshakes while the block is held in reset
    always_comb begin
        w_req0  = s0_axi_awvalid && s0_axi_wvalid;
        w_req1  = s1_axi_awvalid && s1_axi_wvalid;
        w_win   = w_req1 && (!w_req0 || !last_wgrant);
        w_acc   = axi_aresetn && w_state == W_IDLE && (w_req0 || w_req1);
        w_back0 = w_state == W_BACK && !w_gnt;
        w_back1 = w_state == W_BACK && w_gnt;
        w_done  = (w_back0 && s0_axi_bready) || (w_back1 && s1_axi_bready);
        r_req0  = s0_axi_arvalid;
        r_req1  = s1_axi_arvalid;
        r_win   = r_req1 && (!r_req0 || !last_rgrant);
        r_acc   = axi_aresetn && r_state == R_IDLE && (r_req0 || r_req1);
        r_back0 = r_state == R_BACK && !r_gnt;
        r_back1 = r_state == R_BACK && r_gnt;
        r_done  = (r_back0 && s0_axi_rready) || (r_back1 && s1_axi_rready);
    end
    assign s0_axi_awready = w_acc && !w_win;
    assign s0_axi_wready  = w_acc && !w_win;
    assign s1_axi_awready = w_acc && w_win;
    assign s1_axi_wready  = w_acc && w_win;
    assign s0_axi_bvalid  = w_back0;
    assign s1_axi_bvalid  = w_back1;
    assign s0_axi_bresp   = w_back0 ? bresp_q : '0;
    assign s1_axi_bresp   = w_back1 ? bresp_q : '0;
    assign s0_axi_arready = r_acc && !r_win;
    assign s1_axi_arready = r_acc && r_win;
    assign s0_axi_rvalid  = r_back0;
    assign s1_axi_rvalid  = r_back1;
    assign s0_axi_rdata   = r_back0 ? rdata_q : '0;
    assign s1_axi_rdata   = r_back1 ? rdata_q : '0;
    assign s0_axi_rresp   = r_back0 ? rresp_q : '0;
    assign s1_axi_rresp   = r_back1 ? rresp_q : '0;
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state       <= W_IDLE;
            w_gnt         <= 1'b0;
            last_wgrant   <= 1'b1;
            bresp_q       <= '0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (w_acc) begin
                    w_state       <= W_ADDR;
                    w_gnt         <= w_win;
                    m_axi_awaddr  <= w_win ? s1_axi_awaddr : s0_axi_awaddr;
                    m_axi_wdata   <= w_win ? s1_axi_wdata : s0_axi_wdata;
                    m_axi_wstrb   <= w_win ? s1_axi_wstrb : s0_axi_wstrb;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                end
                W_ADDR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready) m_axi_wvalid <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        w_state      <= W_RESP;
                        m_axi_bready <= 1'b1;
                    end
                end
                W_RESP: if (m_axi_bvalid) begin
                    w_state      <= W_BACK;
                    bresp_q      <= m_axi_bresp;
                    m_axi_bready <= 1'b0;
                end
                W_BACK: if (w_done) begin
                    w_state     <= W_IDLE;
                    last_wgrant <= w_gnt;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state       <= R_IDLE;
            r_gnt         <= 1'b0;
            last_rgrant   <= 1'b1;
            rdata_q       <= '0;
            rresp_q       <= '0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (r_acc) begin
                    r_state       <= R_ADDR;
                    r_gnt         <= r_win;
                    m_axi_araddr  <= r_win ? s1_axi_araddr : s0_axi_araddr;
                    m_axi_arvalid <= 1'b1;
                end
                R_ADDR: if (m_axi_arready) begin
                    r_state       <= R_DATA;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                end
                R_DATA: if (m_axi_rvalid) begin
                    r_state      <= R_BACK;
                    rdata_q      <= m_axi_rdata;
                    rresp_q      <= m_axi_rresp;
                    m_axi_rready <= 1'b0;
                end
                R_BACK: if (r_done) begin
                    r_state     <= R_IDLE;
                    last_rgrant <= r_gnt;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb_axil_arbiter_2to1: directed stimulus checked every cycle against a transaction-level model.
module tb_axil_arbiter_2to1;
    localparam int DW = 32, AW = 8, RW = 3, SW = DW / 8 + 1;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] s_awaddr[2], s_araddr[2];
    logic [DW-1:0] s_wdata[2], s_rdata[2];
    logic [SW-1:0] s_wstrb[2];
    logic [RW-1:0] s_bresp[2], s_rresp[2];
    logic s_awvalid[2], s_awready[2], s_wvalid[2], s_wready[2], s_bvalid[2], s_bready[2];
    logic s_arvalid[2], s_arready[2], s_rvalid[2], s_rready[2];
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [RW-1:0] m_bresp, m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    int vec = 0, err = 0, seq = 0;
    int w_order[2];
    int bdone[2] = '{0, 0}, rdone[2] = '{0, 0};
    logic [RW-1:0] b_last[2], rr_last[2];
    logic [DW-1:0] r_last[2];
    int b0, b1, r0, r1;
    bit ok;

    always #5 clk = ~clk;

    axil_arbiter_2to1 dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
        .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
        .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
        .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]),
        .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
        .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
        .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
        .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]),
        .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction model: one in-flight record per direction plus the last winner.
    bit wb, wo, wa, wd, wg, wl = 1'b1;
    logic [AW-1:0] ma = '0;
    logic [DW-1:0] md = '0;
    logic [SW-1:0] ms = '0;
    logic [RW-1:0] mr = '0;
    bit rb, ro, ra, rg, rl = 1'b1;
    logic [AW-1:0] mra = '0;
    logic [DW-1:0] mrd = '0;
    logic [RW-1:0] mrr = '0;

    always @(negedge clk) begin : cmp
        bit q0, q1, win, acc, sel;
        if (!rst_n) begin
            wb = 0; wl = 1; ma = '0; md = '0; ms = '0; mr = '0;
            rb = 0; rl = 1; mra = '0; mrd = '0; mrr = '0;
        end
        q0 = s_awvalid[0] && s_wvalid[0];
        q1 = s_awvalid[1] && s_wvalid[1];
        win = q1 && (!q0 || !wl);
        acc = rst_n && !wb && (q0 || q1);
        chk("w_readies", 64'({s_awready[1], s_awready[0], s_wready[1], s_wready[0]}),
            64'({acc && win, acc && !win, acc && win, acc && !win}));
        chk("m_w_ctrl", 64'({m_awvalid, m_wvalid, m_bready}), 64'({wb && !wa, wb && !wd, wb && wa && wd && !wg}));
        chk("m_w_payload", 64'({m_awaddr, m_wdata, m_wstrb}), 64'({ma, md, ms}));
        for (int n = 0; n < 2; n++) begin
            sel = wb && wg && (wo == n[0]);
            chk($sformatf("s%0d_b", n), 64'({s_bvalid[n], s_bresp[n]}), 64'({sel, sel ? mr : 3'd0}));
        end
        if (rst_n) begin
            if (acc) begin
                wb = 1; wo = win; wa = 0; wd = 0; wg = 0;
                ma = s_awaddr[win]; md = s_wdata[win]; ms = s_wstrb[win];
            end else if (wb) begin
                if (wg && s_bready[wo]) begin wb = 0; wl = wo; end
                if (wa && wd && !wg && m_bvalid) begin wg = 1; mr = m_bresp; end
                if (m_awready) wa = 1;
                if (m_wready) wd = 1;
            end
        end
        q0 = s_arvalid[0];
        q1 = s_arvalid[1];
        win = q1 && (!q0 || !rl);
        acc = rst_n && !rb && (q0 || q1);
        chk("r_readies", 64'({s_arready[1], s_arready[0]}), 64'({acc && win, acc && !win}));
        chk("m_r_ctrl", 64'({m_arvalid, m_rready}), 64'({rb && !ra, rb && ra && !rg}));
        chk("m_araddr", 64'(m_araddr), 64'(mra));
        for (int n = 0; n < 2; n++) begin
            sel = rb && rg && (ro == n[0]);
            chk($sformatf("s%0d_r", n), 64'({s_rvalid[n], s_rdata[n], s_rresp[n]}),
                64'({sel, sel ? mrd : 32'd0, sel ? mrr : 3'd0}));
        end
        if (rst_n) begin
            if (acc) begin
                rb = 1; ro = win; ra = 0; rg = 0; mra = s_araddr[win];
            end else if (rb) begin
                if (rg && s_rready[ro]) begin rb = 0; rl = ro; end
                if (ra && !rg && m_rvalid) begin rg = 1; mrd = m_rdata; mrr = m_rresp; end
                if (m_arready) ra = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (s_bvalid[n] && s_bready[n]) begin bdone[n]++; b_last[n] = s_bresp[n]; end
            if (s_rvalid[n] && s_rready[n]) begin rdone[n]++; r_last[n] = s_rdata[n]; rr_last[n] = s_rresp[n]; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit got = 0;
        s_awaddr[n] = a; s_wdata[n] = d; s_wstrb[n] = s; s_awvalid[n] = 1; s_wvalid[n] = 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_awready[n];
        end
        chk("w_accept_timeout", 64'(got), 64'd1);
        step();
        s_awvalid[n] = 0; s_wvalid[n] = 0;
        w_order[n] = seq++;
    endtask

    task automatic drive_r(input int n, input logic [AW-1:0] a);
        bit got = 0;
        s_araddr[n] = a; s_arvalid[n] = 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_arready[n];
        end
        chk("r_accept_timeout", 64'(got), 64'd1);
        step();
        s_arvalid[n] = 0;
    endtask

    task automatic wait_cnt(input string nm, input bit rd, input int n, input int target);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = (rd ? rdone[n] : bdone[n]) >= target;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            s_awaddr[n] = '0; s_wdata[n] = '0; s_wstrb[n] = '0; s_araddr[n] = '0;
            s_awvalid[n] = 0; s_wvalid[n] = 0; s_arvalid[n] = 0; s_bready[n] = 1; s_rready[n] = 1;
        end
        m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = '0;
        m_arready = 1; m_rvalid = 1; m_rdata = '0; m_rresp = '0;
        rst_n = 0;
        step();
        s_awvalid[0] = 1; s_wvalid[0] = 1; s_arvalid[0] = 1;
        #1 chk("rst_readies_low", 64'({s_awready[0], s_wready[0], s_arready[0]}), 64'd0);
        chk("rst_outputs_zero", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_awaddr, m_araddr}), 64'd0);
        s_awvalid[0] = 0; s_wvalid[0] = 0; s_arvalid[0] = 0;
        do_reset();

        // single s0 write, minimum latency
        drive_w(0, 8'h04, 32'hDEADBEEF, 5'h1F);
        chk("t1_c1_m_aw", 64'({m_awvalid, m_wvalid, m_awaddr}), 64'({2'b11, 8'h04}));
        chk("t1_c1_m_w", 64'({m_wdata, m_wstrb}), 64'({32'hDEADBEEF, 5'h1F}));
        step();
        step();
        chk("t1_c3_s0_b", 64'({s_bvalid[0], s_bresp[0]}), 64'({1'b1, 3'd0}));
        chk("t1_c3_s1_quiet", 64'({s_bvalid[1], s_bresp[1], s_awready[1], s_rvalid[1]}), 64'd0);
        repeat (2) step();

        // simultaneous writes alternate, s0 first after reset
        do_reset();
        b0 = bdone[0]; b1 = bdone[1];
        fork
            drive_w(0, 8'h10, 32'h11110000, 5'h1F);
            drive_w(1, 8'h20, 32'h22220000, 5'h0F);
        join
        wait_cnt("t2_first_pair_done", 0, 1, b1 + 1);
        chk("t2_s0_first", 64'(w_order[0] < w_order[1]), 64'd1);
        fork
            drive_w(0, 8'h30, 32'h33330000, 5'h1F);
            drive_w(1, 8'h40, 32'h44440000, 5'h01);
        join
        wait_cnt("t2_second_pair_done", 0, 1, b1 + 2);
        chk("t2_s0_first_again", 64'(w_order[0] < w_order[1]), 64'd1);
        chk("t2_counts", 64'({bdone[0] - b0, bdone[1] - b1}), 64'({32'd2, 32'd2}));

        // s1 read with requester backpressure
        s_rready[1] = 0; m_rdata = 32'h12345678; m_rresp = '0; r1 = rdone[1];
        drive_r(1, 8'h18);
        chk("t3_c1_m_ar", 64'({m_arvalid, m_araddr}), 64'({1'b1, 8'h18}));
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = s_rvalid[1];
        end
        chk("t3_rvalid_timeout", 64'(ok), 64'd1);
        m_rdata = 32'hFFFF0000;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", 64'({s_rvalid[1], s_rdata[1], s_rresp[1]}), 64'({1'b1, 32'h12345678, 3'd0}));
            step();
        end
        s_rready[1] = 1;
        step();
        chk("t3_released", 64'({s_rvalid[1], rdone[1] - r1}), 64'({1'b0, 32'd1}));

        // write data channel stalled three cycles behind the address channel
        m_wready = 0; m_bresp = 3'd2; b0 = bdone[0];
        drive_w(0, 8'h44, 32'hCAFEF00D, 5'h03);
        chk("t4_c1_both", 64'({m_awvalid, m_wvalid}), 64'b11);
        step();
        chk("t4_aw_first", 64'({m_awvalid, m_wvalid}), 64'b01);
        step();
        step();
        chk("t4_w_waits", 64'({m_wvalid, m_bready}), 64'b10);
        m_wready = 1;
        step();
        chk("t4_w_done", 64'({m_wvalid, m_bready}), 64'b01);
        wait_cnt("t4_resp", 0, 0, b0 + 1);
        repeat (5) step();
        chk("t4_one_resp", 64'(bdone[0] - b0), 64'd1);
        chk("t4_bresp", 64'(b_last[0]), 64'd2);
        m_bresp = '0;

        // concurrent s0 write and s1 read
        m_rdata = 32'hA5A55A5A; m_rresp = 3'd1;
        b0 = bdone[0]; b1 = bdone[1]; r0 = rdone[0]; r1 = rdone[1];
        fork
            drive_w(0, 8'h08, 32'h0BADCAFE, 5'h1F);
            drive_r(1, 8'h0C);
        join
        wait_cnt("t5_w", 0, 0, b0 + 1);
        wait_cnt("t5_r", 1, 1, r1 + 1);
        chk("t5_rdata", 64'({r_last[1], rr_last[1]}), 64'({32'hA5A55A5A, 3'd1}));
        chk("t5_no_cross", 64'({bdone[1] - b1, rdone[0] - r0}), 64'd0);

        // reset during the response wait aborts the write
        m_bvalid = 0; b0 = bdone[0];
        drive_w(0, 8'h50, 32'h5555AAAA, 5'h1F);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = m_bready;
        end
        chk("t6_reach_resp", 64'(ok), 64'd1);
        #1 rst_n = 0;
        #1 chk("t6_async_m", 64'({m_bready, m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb}), 64'd0);
        chk("t6_async_s", 64'({s_bvalid[0], s_bresp[0], s_bvalid[1], s_awready[0], s_awready[1]}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        m_bvalid = 1; m_bresp = '0; b1 = bdone[1];
        drive_w(1, 8'h60, 32'h66660000, 5'h1F);
        wait_cnt("t6_s1_done", 0, 1, b1 + 1);
        chk("t6_no_stale_s0", 64'(bdone[0] - b0), 64'd0);
        chk("t6_s1_bresp", 64'(b_last[1]), 64'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, miscompares %0d", err);
        $fatal(1);
    end
endmodule

// File: doc/axil_arbiter_2to1.md
AXIL_ARBITER_2TO1 -- requirements
Module: axil_arbiter_2to1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, bresp/rresp width.
REQ-004 SHALL use STRB_WIDTH = DATA_WIDTH/8+1 for every wstrb port, matching the downstream interconnect.
REQ-005 SHALL have port axi_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port axi_aresetn, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have, per requester N in {0,1}, ports sN_axi_awaddr, sN_axi_awvalid, sN_axi_awready: in, in, out; ADDR_WIDTH, 1, 1; write address.
REQ-008 SHALL have ports sN_axi_wdata, sN_axi_wstrb, sN_axi_wvalid, sN_axi_wready: in, in, in, out; DATA_WIDTH, STRB_WIDTH, 1, 1; write data.
REQ-009 SHALL have ports sN_axi_bresp, sN_axi_bvalid, sN_axi_bready: out, out, in; RESP_WIDTH, 1, 1; write response.
REQ-010 SHALL have ports sN_axi_araddr, sN_axi_arvalid, sN_axi_arready: in, in, out; ADDR_WIDTH, 1, 1; read address.
REQ-011 SHALL have ports sN_axi_rdata, sN_axi_rresp, sN_axi_rvalid, sN_axi_rready: out, out, out, in; DATA_WIDTH, RESP_WIDTH, 1, 1; read data.
REQ-012 SHALL have a downstream port set m_axi_* mirroring REQ-007..011 with all directions inverted, for connection to the interconnect's slave port.

Function
REQ-013 SHALL run independent write and read arbiters; each allows one outstanding transaction and performs no address decode.
REQ-014 Write FSM SHALL have states W_IDLE, W_ADDR, W_RESP, W_BACK.
REQ-015 A requester SHALL request a write when sN_axi_awvalid && sN_axi_wvalid.
REQ-016 In W_IDLE, the winner's sN_axi_awready and sN_axi_wready SHALL be asserted combinationally in the same cycle.
REQ-017 On that handshake edge the block SHALL capture awaddr, wdata, wstrb and the grant index, then go to W_ADDR.
REQ-018 In W_ADDR, registered m_axi_awvalid and m_axi_wvalid SHALL be 1.
REQ-019 In W_ADDR, each of m_axi_awvalid and m_axi_wvalid SHALL drop independently on its own handshake; when both are done the FSM SHALL go to W_RESP with m_axi_bready=1.
REQ-020 In W_RESP, on m_axi_bvalid && m_axi_bready the block SHALL capture m_axi_bresp, clear m_axi_bready and go to W_BACK.
REQ-021 In W_BACK, the granted sN_axi_bvalid SHALL be 1 with the captured bresp.
REQ-022 On sN_axi_bready in W_BACK the FSM SHALL go to W_IDLE and record the granted index as last_wgrant.
REQ-023 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_BACK, mirroring REQ-016..022: arvalid request, comb arready, m_axi_arvalid, m_axi_rready, sN_axi_rvalid with captured rdata and rresp, and last_rgrant.
REQ-024 Arbitration SHALL be round-robin per direction: a single requester wins; with simultaneous requests the index != last grant wins.
REQ-025 The non-granted requester's ready and valid outputs SHALL be 0 at all times.
REQ-026 In any non-IDLE state all sN ready outputs of that direction SHALL be 0, and new requests wait.
REQ-027 Downstream payload outputs SHALL hold the captured values from W_ADDR/R_ADDR until the next capture.
REQ-028 Minimum write latency SHALL be: accept at cycle 0, m_axi_awvalid/wvalid at cycle 1, sN_axi_bvalid at cycle 3 when the downstream is always ready. Read latency SHALL be identical.
REQ-029 A write and a read SHALL proceed concurrently, including to the same or different requesters.
REQ-030 Backpressure SHALL be supported indefinitely in every state with no timeout.

Reset
REQ-031 While axi_aresetn=0, both FSMs SHALL be in IDLE, last_wgrant=last_rgrant=1, and every valid, ready and resp output SHALL be 0; data and address outputs SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no completion sent to the requester.

Verification
REQ-033 s0 write awaddr=0x04, wdata=0xDEADBEEF, wstrb=all-ones; downstream always ready, bresp=0 -> m_axi_awaddr=0x04 at cycle 1; s0_axi_bvalid=1, bresp=0 at cycle 3; s1 outputs remain 0.
REQ-034 s0 and s1 both request writes at cycle 0 after reset -> s0 served first, then s1; a repeat simultaneous request serves s0 then s1 (alternation).
REQ-035 s1 read araddr=0x18, downstream rdata=0x12345678, rresp=0, s1_axi_rready held 0 for 5 cycles -> s1_axi_rvalid stays 1 with stable data until rready=1, then R_IDLE.
REQ-036 m_axi_wready delayed 3 cycles after m_axi_awready -> awvalid drops first, wvalid drops on its own handshake, exactly one bresp is forwarded.
REQ-037 s0 write concurrent with s1 read -> both complete with correct data and no cross-routing.
REQ-038 axi_aresetn pulsed low during W_RESP -> all outputs are 0 asynchronously; after release a new s1 write completes normally.
